// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the ALU-sharing arbiter: FSM states,
// ALUControl encodings, flag bit positions and the legal-op decoder.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    function automatic logic is_legal_op(input logic [2:0] ctrl);
        logic legal;
        case (ctrl)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester request/response channels plus the ALU operand/result bus.
// slave = the arbiter, master = requesters together with the ALU.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*3-1:0]  req_ctrl;

    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [31:0]           rsp_result;
    logic [3:0]            rsp_flags;
    logic                  rsp_err;

    logic [31:0]           alu_a;
    logic [31:0]           alu_b;
    logic [2:0]            alu_ctrl;
    logic [31:0]           alu_result;
    logic                  alu_z;
    logic                  alu_n;
    logic                  alu_v;
    logic                  alu_c;

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
        input  alu_result, alu_z, alu_n, alu_v, alu_c,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err,
        output alu_a, alu_b, alu_ctrl
    );

    modport master (
        output req_valid, req_a, req_b, req_ctrl, rsp_ready,
        output alu_result, alu_z, alu_n, alu_v, alu_c,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err,
        input  alu_a, alu_b, alu_ctrl
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or above
// i_ptr (wrapping modulo N) wins; returns one-hot grant and its index.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan N positions starting at the pointer; the first hit locks the grant.
    always_comb begin
        int   v_pos;
        logic v_hit;
        logic v_found;
        o_grant = '0;
        o_idx   = '0;
        v_found = 1'b0;
        v_pos   = 0;
        v_hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            v_pos = int'(i_ptr) + k;
            v_pos = (v_pos >= N) ? (v_pos - N) : v_pos;
            v_hit = i_req[v_pos] & ~v_found;
            o_grant[v_pos] = o_grant[v_pos] | v_hit;
            o_idx   = v_hit ? IDX_W'(v_pos) : o_idx;
            v_found = v_found | v_hit;
        end
        o_any = v_found;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit ALU among NUM_REQ requesters: IDLE accepts one op,
// EXEC lets the ALU evaluate, RESP holds the result until the owner takes it.
// Optional: `define ALU_ARB_ILLEGAL_OP_EN to answer illegal codes directly.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [NUM_REQ-1:0]  w_grant;
    logic [NUM_REQ-1:0]  w_rsp_valid;
    logic                w_any;
    logic                w_accept;
    logic                w_handshake;
    logic                w_skip_exec;
    logic [WIDTH-1:0]    w_win_a;
    logic [WIDTH-1:0]    w_win_b;
    logic [2:0]          w_win_ctrl;
    logic [3:0]          w_alu_flags;
    logic [WIDTH-1:0]    r_alu_a;
    logic [WIDTH-1:0]    r_alu_b;
    logic [2:0]          r_alu_ctrl;
    logic [WIDTH-1:0]    r_rsp_result;
    logic [3:0]          r_rsp_flags;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_win_a     = bus.req_a[int'(w_idx)*WIDTH +: WIDTH];
    assign w_win_b     = bus.req_b[int'(w_idx)*WIDTH +: WIDTH];
    assign w_win_ctrl  = bus.req_ctrl[int'(w_idx)*3 +: 3];
    assign w_accept    = (r_state == IDLE) && w_any;
    assign w_handshake = (r_state == RESP) && bus.rsp_ready[r_owner];
    assign w_ptr_nxt   = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : (r_owner + IDX_W'(1));

`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign w_skip_exec = ~is_legal_op(w_win_ctrl);
`else
    assign w_skip_exec = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; illegal ops (when enabled) bypass the ALU cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_skip_exec ? RESP : EXEC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (w_handshake) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Priority pointer moves past the owner only once its response is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_handshake) begin
            r_ptr <= w_ptr_nxt;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Operand capture; ctrl stays untouched for ops that never reach the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= 3'b000;
        end else if (w_accept) begin
            r_owner    <= w_idx;
            r_alu_a    <= w_win_a;
            r_alu_b    <= w_win_b;
            r_alu_ctrl <= w_skip_exec ? r_alu_ctrl : w_win_ctrl;
        end else begin
            r_owner    <= r_owner;
            r_alu_a    <= r_alu_a;
            r_alu_b    <= r_alu_b;
            r_alu_ctrl <= r_alu_ctrl;
        end
    end

    // Pack ALU flags into {Z,N,V,C} order.
    always_comb begin
        w_alu_flags         = 4'b0000;
        w_alu_flags[FLAG_Z] = bus.alu_z;
        w_alu_flags[FLAG_N] = bus.alu_n;
        w_alu_flags[FLAG_V] = bus.alu_v;
        w_alu_flags[FLAG_C] = bus.alu_c;
    end

    // Response capture at the end of EXEC, or directly for a rejected op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_result <= '0;
            r_rsp_flags  <= 4'b0000;
        end else if (w_accept && w_skip_exec) begin
            r_rsp_result <= '0;
            r_rsp_flags  <= 4'b1000;
        end else if (r_state == EXEC) begin
            r_rsp_result <= bus.alu_result;
            r_rsp_flags  <= w_alu_flags;
        end else begin
            r_rsp_result <= r_rsp_result;
            r_rsp_flags  <= r_rsp_flags;
        end
    end

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic r_rsp_err;

    // Error marker travels with the response it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if (w_accept) begin
            r_rsp_err <= w_skip_exec;
        end else begin
            r_rsp_err <= r_rsp_err;
        end
    end

    assign bus.rsp_err = r_rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // One-hot response valid toward the owner.
    always_comb begin
        w_rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rsp_valid[i] = (r_state == RESP) && (r_owner == IDX_W'(i));
        end
    end

    assign bus.req_ready  = w_accept ? w_grant : '0;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_ctrl   = r_alu_ctrl;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed ops push expected
// responses; a negedge monitor pops and compares on each response handshake.
module tb_alu_share_arbiter;

    localparam int NR = 2;

    typedef struct packed {
        logic [2:0]  owner;
        logic [31:0] res;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [32:0] m_sum;
    logic [31:0] m_res;
    logic        m_v;
    logic        m_c;

    int g;
    int c;
    int lat;
    int gidx[4];
    int gcyc[4];
    int ng;

    alu_share_arbiter_if #(.NUM_REQ(NR)) bus ();

    alu_share_arbiter #(.NUM_REQ(NR), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU driving the shared result/flag inputs.
    always_comb begin
        m_sum = 33'd0;
        m_res = 32'd0;
        m_v   = 1'b0;
        m_c   = 1'b0;
        case (bus.alu_ctrl)
            3'b000: begin
                m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                m_res = m_sum[31:0];
                m_c   = m_sum[32];
                m_v   = (bus.alu_a[31] == bus.alu_b[31]) && (m_res[31] != bus.alu_a[31]);
            end
            3'b001: begin
                m_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
                m_res = m_sum[31:0];
                m_c   = m_sum[32];
                m_v   = (bus.alu_a[31] != bus.alu_b[31]) && (m_res[31] != bus.alu_a[31]);
            end
            3'b010: m_res = bus.alu_a & bus.alu_b;
            3'b011: m_res = bus.alu_a | bus.alu_b;
            3'b101: m_res = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
            default: m_res = 32'd0;
        endcase
        bus.alu_result = m_res;
        bus.alu_z      = (m_res == 32'd0);
        bus.alu_n      = m_res[31];
        bus.alu_v      = m_v;
        bus.alu_c      = m_c;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] ctrl);
        bus.req_valid[idx]      = 1'b1;
        bus.req_a[idx*32 +: 32] = a;
        bus.req_b[idx*32 +: 32] = b;
        bus.req_ctrl[idx*3 +: 3] = ctrl;
    endtask

    task automatic push_exp(input int owner, input logic [31:0] r, input logic [3:0] f,
                            input logic e);
        exp_t x;
        x.owner = 3'(owner);
        x.res   = r;
        x.flags = f;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    // Returns at the negedge where req_ready is first non-zero.
    task automatic wait_grant(output int idx, output int cycles);
        idx    = -1;
        cycles = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                for (int i = 0; i < NR; i++) begin
                    if (bus.req_ready[i]) idx = i;
                end
                cycles = k;
                return;
            end
        end
    endtask

    // Counts negedges until rsp_valid rises; -1 on timeout.
    task automatic wait_rsp(output int l);
        l = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin
                l = k;
                return;
            end
        end
    endtask

    // Scoreboard monitor: compare on every response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("rsp_owner",  64'(i), 64'(mon_e.owner));
                        chk("rsp_result", 64'(bus.rsp_result), 64'(mon_e.res));
                        chk("rsp_flags",  64'(bus.rsp_flags), 64'(mon_e.flags));
                        chk("rsp_err",    64'(bus.rsp_err), 64'(mon_e.err));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_ctrl  = '0;
        bus.rsp_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {bus.req_ready, bus.rsp_valid, bus.rsp_flags, bus.rsp_err, bus.alu_ctrl}, 64'd0);
        chk("reset_res_a", {bus.rsp_result, bus.alu_a}, 64'd0);
        chk("reset_b", 64'(bus.alu_b), 64'd0);
        tick();
        rst = 1'b0;

        // Single ADD on requester 0 with response backpressure.
        set_req(0, 32'd5, 32'd3, 3'b000);
        wait_grant(g, c);
        chk("t1_grant", 64'(g), 64'd0);
        push_exp(0, 32'd8, 4'b0000, 1'b0);
        tick();
        bus.req_valid[0] = 1'b0;
        wait_rsp(lat);
        chk("t1_latency", 64'(lat), 64'd2);
        chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t1_alu_ab", {bus.alu_a, bus.alu_b}, 64'h0000_0005_0000_0003);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) set_req(1, 32'h8000_0000, 32'd1, 3'b001);
            if (i == 2) bus.rsp_ready = 2'b10;
            @(negedge clk);
            chk("bp_hold", {bus.rsp_valid, bus.req_ready, bus.rsp_flags}, 64'b01_00_0000);
            chk("bp_result", 64'(bus.rsp_result), 64'd8);
        end
        tick();
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        tick();
        wait_grant(g, c);
        chk("bp_next_grant", 64'(g), 64'd1);
        chk("bp_release_cycles", 64'(c), 64'd0);
        push_exp(1, 32'h7FFF_FFFF, 4'b0011, 1'b0);
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = 2'b11;
        wait_rsp(lat);
        chk("sub_latency", 64'(lat), 64'd2);

        // Contention from reset: both requesters valid, rsp_ready held high.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 32'd1, 32'd1, 3'b000);
        set_req(1, 32'h0000_00F0, 32'h0000_003C, 3'b010);
        for (int k = 0; k < 4; k++) begin
            gidx[k] = -1;
            gcyc[k] = -100;
        end
        ng = 0;
        for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                gidx[ng] = bus.req_ready[1] ? 1 : 0;
                gcyc[ng] = cyc;
                if (gidx[ng] == 0) push_exp(0, 32'd2, 4'b0000, 1'b0);
                else               push_exp(1, 32'h0000_0030, 4'b0000, 1'b0);
                ng++;
            end
        end
        tick();
        bus.req_valid = '0;
        for (int k = 0; k < 4; k++) chk("rr_order", 64'(gidx[k]), 64'(k % 2));
        for (int k = 1; k < 4; k++) chk("rr_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'd3);
        wait_rsp(lat);
        chk("rr_last_latency", 64'(lat), 64'd2);

        // ADD with carry-out to zero, then leave ptr at 1.
        tick();
        set_req(0, 32'hFFFF_FFFF, 32'd1, 3'b000);
        wait_grant(g, c);
        chk("carry_grant", 64'(g), 64'd0);
        push_exp(0, 32'd0, 4'b1001, 1'b0);
        tick();
        bus.req_valid = '0;
        wait_rsp(lat);

        // Reset while requester 1's SUB is in EXEC: no response, ptr back to 0.
        tick();
        set_req(1, 32'd7, 32'd7, 3'b001);
        wait_grant(g, c);
        chk("rst_victim_grant", 64'(g), 64'd1);
        tick();
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        chk("rst_alu_cleared", {bus.alu_a, bus.alu_b}, 64'd0);
        tick();
        set_req(0, 32'h0F0F_0000, 32'h0000_F0F0, 3'b011);
        set_req(1, 32'hFFFF_FFFF, 32'd1, 3'b101);
        wait_grant(g, c);
        chk("rst_ptr_zero", 64'(g), 64'd0);
        push_exp(0, 32'h0F0F_F0F0, 4'b0000, 1'b0);
        tick();
        bus.req_valid[0] = 1'b0;
        wait_grant(g, c);
        chk("post_rst_second", 64'(g), 64'd1);
        chk("post_rst_gap", 64'(c), 64'd2);
        push_exp(1, 32'd1, 4'b0000, 1'b0);
        tick();
        bus.req_valid = '0;
        wait_rsp(lat);

        // Illegal ALUControl 111.
        tick();
        set_req(0, 32'd9, 32'd9, 3'b111);
        wait_grant(g, c);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        push_exp(0, 32'd0, 4'b1000, 1'b1);
`else
        push_exp(0, 32'd0, 4'b1000, 1'b0);
`endif
        tick();
        bus.req_valid = '0;
        wait_rsp(lat);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        chk("illegal_latency", 64'(lat), 64'd1);
        chk("illegal_ctrl_kept", 64'(bus.alu_ctrl), 64'b101);
`else
        chk("illegal_latency", 64'(lat), 64'd2);
        chk("illegal_ctrl_passed", 64'(bus.alu_ctrl), 64'b111);
`endif

        for (int k = 0; k < 10; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
